// File: rtl/t05_cb_walker.sv
// Codebook walker: depth-first, left-first traversal of a Huffman tree, one codeword per leaf.
// Node reads use req/vld; codewords leave through a valid/ready port and stall the walk.
module t05_cb_walker #(
  parameter int SYM_W   = 8,
  parameter int IDX_W   = 7,
  parameter int MAX_LEN = 128,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [IDX_W-1:0]   i_root_idx,
  output logic               o_node_req,
  output logic [IDX_W-1:0]   o_node_addr,
  input  logic               i_node_vld,
  input  logic [SYM_W:0]     i_node_left,
  input  logic [SYM_W:0]     i_node_right,
  output logic               o_cw_valid,
  input  logic               i_cw_ready,
  output logic [SYM_W-1:0]   o_cw_sym,
  output logic [MAX_LEN-1:0] o_cw_code,
  output logic [LEN_W-1:0]   o_cw_len,
  output logic [SYM_W:0]     o_cw_count,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err_overflow
);

  localparam int STK_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DESCEND,
    S_EMIT,
    S_BACKTRACK,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  state_t             w_eval_nxt;

  logic [IDX_W-1:0]   r_cur;
  logic [SYM_W:0]     r_left;
  logic [SYM_W:0]     r_right;
  logic [MAX_LEN-1:0] r_path;
  logic [LEN_W-1:0]   r_len;
  logic [SYM_W-1:0]   r_cw_sym;
  logic [SYM_W:0]     r_cw_count;
  logic               r_err;
  logic [SYM_W:0]     r_stk [MAX_LEN];

  logic               w_at_max;
  logic               w_len_zero;
  logic               w_eval_en;
  logic [SYM_W:0]     w_child;
  logic [SYM_W:0]     w_stk_top;
  logic               w_is_leaf;
  logic               w_is_null;
  logic [STK_AW-1:0]  w_stk_wr_idx;
  logic [STK_AW-1:0]  w_stk_rd_idx;

  assign w_at_max     = (r_len == LEN_MAX);
  assign w_len_zero   = (r_len == '0);
  assign w_stk_wr_idx = STK_AW'(r_len);
  assign w_stk_rd_idx = STK_AW'(r_len - 1'b1);
  assign w_stk_top    = r_stk[w_stk_rd_idx];

  // A child is evaluated on descent (left) or when backtracking flips a left move to right.
  assign w_eval_en = ((r_state == S_DESCEND) && !w_at_max) ||
                     ((r_state == S_BACKTRACK) && !w_len_zero && !r_path[0]);
  assign w_child   = (r_state == S_DESCEND) ? r_left : w_stk_top;
  assign w_is_leaf = !w_child[SYM_W];
  assign w_is_null = w_child[SYM_W] && w_child[SYM_W-1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_eval_nxt = S_FETCH;
    if (w_is_null) begin
      w_eval_nxt = S_BACKTRACK;
    end else if (w_is_leaf) begin
      w_eval_nxt = S_EMIT;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (i_node_vld) begin
          w_state_nxt = S_DESCEND;
        end
      end
      S_DESCEND: begin
        if (w_at_max) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = w_eval_nxt;
        end
      end
      S_EMIT: begin
        if (i_cw_ready) begin
          w_state_nxt = S_BACKTRACK;
        end
      end
      S_BACKTRACK: begin
        if (w_len_zero) begin
          w_state_nxt = S_DONE;
        end else if (!r_path[0]) begin
          w_state_nxt = w_eval_nxt;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_node_req = (r_state == S_FETCH);
    o_cw_valid = (r_state == S_EMIT);
    o_busy     = (r_state != S_IDLE);
    o_done     = (r_state == S_DONE);
  end

  assign o_node_addr    = r_cur;
  assign o_cw_sym       = r_cw_sym;
  assign o_cw_code      = r_path;
  assign o_cw_len       = r_len;
  assign o_cw_count     = r_cw_count;
  assign o_err_overflow = r_err;

  // Walk datapath; path bits at or above len are kept zero by construction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur      <= '0;
      r_left     <= '0;
      r_right    <= '0;
      r_path     <= '0;
      r_len      <= '0;
      r_cw_sym   <= '0;
      r_cw_count <= '0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_cur      <= i_root_idx;
            r_path     <= '0;
            r_len      <= '0;
            r_cw_count <= '0;
            r_err      <= 1'b0;
          end
        end
        S_FETCH: begin
          if (i_node_vld) begin
            r_left  <= i_node_left;
            r_right <= i_node_right;
          end
        end
        S_DESCEND: begin
          if (!w_at_max) begin
            r_path <= {r_path[MAX_LEN-2:0], 1'b0};
            r_len  <= r_len + 1'b1;
          end
        end
        S_EMIT: begin
          if (i_cw_ready) begin
            r_cw_count <= r_cw_count + 1'b1;
          end
        end
        S_BACKTRACK: begin
          if (!w_len_zero) begin
            if (!r_path[0]) begin
              r_path[0] <= 1'b1;
            end else begin
              r_path <= r_path >> 1;
              r_len  <= r_len - 1'b1;
            end
          end
        end
        S_ERR: r_err <= 1'b1;
        default: ;
      endcase

      if (w_eval_en) begin
        if (w_is_leaf) begin
          r_cw_sym <= w_child[SYM_W-1:0];
        end else if (!w_is_null) begin
          r_cur <= w_child[IDX_W-1:0];
        end
      end
    end
  end

  // Pending right children; contents are only read back after being written in this walk
  always_ff @(posedge clk) begin
    if ((r_state == S_DESCEND) && !w_at_max) begin
      r_stk[w_stk_wr_idx] <= r_right;
    end
  end

endmodule

// File: tb/tb_t05_cb_walker.sv
// Directed bench for t05_cb_walker: table of trees with expected codewords plus overflow/reset sequences.
module tb_t05_cb_walker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start;
  logic [6:0]   root;
  logic         node_req;
  logic [6:0]   node_addr;
  logic         node_vld;
  logic [8:0]   node_left, node_right;
  logic         cw_valid, cw_ready;
  logic [7:0]   cw_sym;
  logic [127:0] cw_code;
  logic [7:0]   cw_len;
  logic [8:0]   cw_count;
  logic         busy, done, err;

  t05_cb_walker u_dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_root_idx(root),
    .o_node_req(node_req), .o_node_addr(node_addr), .i_node_vld(node_vld),
    .i_node_left(node_left), .i_node_right(node_right),
    .o_cw_valid(cw_valid), .i_cw_ready(cw_ready), .o_cw_sym(cw_sym),
    .o_cw_code(cw_code), .o_cw_len(cw_len), .o_cw_count(cw_count),
    .o_busy(busy), .o_done(done), .o_err_overflow(err)
  );

  // Shallow instance for the depth-overflow case
  logic         s_start;
  logic [6:0]   s_root;
  logic         s_req;
  logic [6:0]   s_addr;
  logic         s_vld;
  logic [8:0]   s_left, s_right;
  logic         s_cwv;
  logic [7:0]   s_sym;
  logic [3:0]   s_code;
  logic [2:0]   s_len;
  logic [8:0]   s_count;
  logic         s_busy, s_done, s_err;

  t05_cb_walker #(.MAX_LEN(4)) u_small (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_root_idx(s_root),
    .o_node_req(s_req), .o_node_addr(s_addr), .i_node_vld(s_vld),
    .i_node_left(s_left), .i_node_right(s_right),
    .o_cw_valid(s_cwv), .i_cw_ready(1'b1), .o_cw_sym(s_sym),
    .o_cw_code(s_code), .o_cw_len(s_len), .o_cw_count(s_count),
    .o_busy(s_busy), .o_done(s_done), .o_err_overflow(s_err)
  );

  localparam logic [8:0] NUL = 9'h180;
  function automatic logic [8:0] lf(input logic [7:0] s);
    return {1'b0, s};
  endfunction
  function automatic logic [8:0] nd(input logic [6:0] i);
    return {2'b10, i};
  endfunction

  logic [8:0] mem_l [128];
  logic [8:0] mem_r [128];

  typedef struct packed {
    logic [6:0] root;
    logic [3:0] delay;
    logic [3:0] stall;
    logic [3:0] n;
    logic [4:0] first;
  } vec_t;
  typedef struct packed {
    logic [7:0] sym;
    logic [7:0] code;
    logic [7:0] len;
  } cw_t;

  vec_t vecs [7];
  cw_t  expcw [11];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Memory responder, codeword consumer and protocol monitor for the main instance
  int           delay_cfg, stall_cfg, stall_left, rd_wait;
  int           got_n, done_cnt, viol;
  logic [8:0]   done_val;
  logic [7:0]   got_sym [16];
  logic [127:0] got_code [16];
  logic [7:0]   got_len [16];
  logic         p_req, p_vld, p_cwv, p_rdy;
  logic [6:0]   p_addr;
  logic [7:0]   p_sym, p_len;
  logic [127:0] p_code;

  always @(negedge clk) begin
    if (!rst_n) begin
      node_vld = 1'b0; node_left = '0; node_right = '0; cw_ready = 1'b1;
      rd_wait = 0; stall_left = 0;
      p_req = 1'b0; p_vld = 1'b0; p_cwv = 1'b0; p_rdy = 1'b1;
    end else begin
      if (p_req && !p_vld && (!node_req || node_addr != p_addr)) viol++;
      if (cw_valid && node_req) viol++;
      if (p_cwv && !p_rdy &&
          (!cw_valid || cw_sym != p_sym || cw_code != p_code || cw_len != p_len)) viol++;
      if (node_req) begin
        if (rd_wait >= delay_cfg) begin
          node_vld = 1'b1; node_left = mem_l[node_addr]; node_right = mem_r[node_addr];
          rd_wait = 0;
        end else begin
          node_vld = 1'b0; rd_wait++;
        end
      end else begin
        node_vld = 1'b0; rd_wait = 0;
      end
      if (cw_valid) begin
        if (stall_left > 0) begin
          cw_ready = 1'b0; stall_left--;
        end else begin
          cw_ready = 1'b1; stall_left = stall_cfg;
          if (got_n < 16) begin
            got_sym[got_n] = cw_sym; got_code[got_n] = cw_code; got_len[got_n] = cw_len;
          end
          got_n++;
        end
      end else begin
        cw_ready = 1'b1;
      end
      if (done) begin
        done_cnt++; done_val = cw_count;
      end
      p_req = node_req; p_vld = node_vld; p_addr = node_addr;
      p_cwv = cw_valid; p_rdy = cw_ready; p_sym = cw_sym; p_code = cw_code; p_len = cw_len;
    end
  end

  int s_cw_seen, s_done_cnt;
  always @(negedge clk) begin
    if (!rst_n) begin
      s_vld = 1'b0; s_left = '0; s_right = '0;
    end else begin
      s_vld = s_req; s_left = mem_l[s_addr]; s_right = mem_r[s_addr];
      if (s_cwv) s_cw_seen++;
      if (s_done) s_done_cnt++;
    end
  end

  task automatic run_case(input int i);
    vec_t v;
    int   k;
    cw_t  e;
    v = vecs[i];
    delay_cfg = int'(v.delay); stall_cfg = int'(v.stall); stall_left = stall_cfg;
    got_n = 0; done_cnt = 0; done_val = '0; viol = 0;
    @(negedge clk); start = 1'b1; root = v.root;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (busy && k < 3000) begin
      @(negedge clk); k++;
    end
    chk($sformatf("c%0d busy_end", i), 128'(busy), 128'(0));
    chk($sformatf("c%0d n_cw", i), 128'(got_n), 128'(v.n));
    for (int j = 0; j < int'(v.n) && j < got_n; j++) begin
      e = expcw[int'(v.first) + j];
      chk($sformatf("c%0d cw%0d sym", i, j), 128'(got_sym[j]), 128'(e.sym));
      chk($sformatf("c%0d cw%0d code", i, j), got_code[j], 128'(e.code));
      chk($sformatf("c%0d cw%0d len", i, j), 128'(got_len[j]), 128'(e.len));
    end
    chk($sformatf("c%0d done_pulses", i), 128'(done_cnt), 128'(1));
    chk($sformatf("c%0d cw_count", i), 128'(done_val), 128'(v.n));
    chk($sformatf("c%0d protocol", i), 128'(viol), 128'(0));
    chk($sformatf("c%0d err", i), 128'(err), 128'(0));
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; root = '0; s_start = 1'b0; s_root = '0;
    delay_cfg = 0; stall_cfg = 0; got_n = 0; done_cnt = 0; viol = 0; done_val = '0;
    s_cw_seen = 0; s_done_cnt = 0;

    for (int a = 0; a < 128; a++) begin
      mem_l[a] = NUL; mem_r[a] = NUL;
    end
    mem_l[3]  = lf(8'h41);  mem_r[3]  = lf(8'h42);
    mem_l[5]  = nd(7'd2);   mem_r[5]  = lf(8'h43);
    mem_l[2]  = lf(8'h41);  mem_r[2]  = lf(8'h42);
    mem_l[6]  = lf(8'h41);  mem_r[6]  = NUL;
    mem_l[7]  = NUL;        mem_r[7]  = nd(7'd8);
    mem_l[8]  = lf(8'h10);  mem_r[8]  = NUL;
    mem_l[9]  = lf(8'h01);  mem_r[9]  = nd(7'd10);
    mem_l[10] = nd(7'd11);  mem_r[10] = lf(8'h04);
    mem_l[11] = lf(8'h02);  mem_r[11] = lf(8'h03);
    for (int a = 20; a < 24; a++) begin
      mem_l[a] = nd(7'(a + 1)); mem_r[a] = lf(8'(a));
    end
    mem_l[24] = lf(8'h18);  mem_r[24] = lf(8'h19);

    //              root   dly   stall n     first
    vecs[0] = '{7'd3, 4'd0, 4'd0, 4'd2, 5'd0};
    vecs[1] = '{7'd5, 4'd0, 4'd0, 4'd3, 5'd2};
    vecs[2] = '{7'd5, 4'd0, 4'd5, 4'd3, 5'd2};
    vecs[3] = '{7'd5, 4'd3, 4'd0, 4'd3, 5'd2};
    vecs[4] = '{7'd6, 4'd0, 4'd0, 4'd1, 5'd5};
    vecs[5] = '{7'd7, 4'd0, 4'd0, 4'd1, 5'd6};
    vecs[6] = '{7'd9, 4'd2, 4'd2, 4'd4, 5'd7};
    expcw[0]  = '{8'h41, 8'b0,   8'd1};
    expcw[1]  = '{8'h42, 8'b1,   8'd1};
    expcw[2]  = '{8'h41, 8'b00,  8'd2};
    expcw[3]  = '{8'h42, 8'b01,  8'd2};
    expcw[4]  = '{8'h43, 8'b1,   8'd1};
    expcw[5]  = '{8'h41, 8'b0,   8'd1};
    expcw[6]  = '{8'h10, 8'b10,  8'd2};
    expcw[7]  = '{8'h01, 8'b0,   8'd1};
    expcw[8]  = '{8'h02, 8'b100, 8'd3};
    expcw[9]  = '{8'h03, 8'b101, 8'd3};
    expcw[10] = '{8'h04, 8'b11,  8'd2};

    repeat (3) @(negedge clk);
    chk("rst ctrl", 128'({node_req, cw_valid, busy, done, err}), 128'(0));
    chk("rst data", 128'({cw_count, cw_len, node_addr, cw_sym}), 128'(0));
    chk("rst code", cw_code, 128'(0));
    chk("rst small", 128'({s_req, s_cwv, s_busy, s_done, s_err, s_count}), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_case(i);

    // Depth overflow on the 4-level instance
    @(negedge clk); s_start = 1'b1; s_root = 7'd20;
    @(negedge clk); s_start = 1'b0;
    k = 0;
    while (s_busy && k < 500) begin
      @(negedge clk); k++;
    end
    chk("ovf busy", 128'(s_busy), 128'(0));
    chk("ovf err", 128'(s_err), 128'(1));
    chk("ovf cw", 128'(s_cw_seen), 128'(0));
    chk("ovf done", 128'(s_done_cnt), 128'(0));

    // A new start clears the flag; a second start while busy is ignored
    @(negedge clk); s_start = 1'b1; s_root = 7'd3;
    @(negedge clk); s_root = 7'd20;
    chk("clr err", 128'(s_err), 128'(0));
    @(negedge clk); s_start = 1'b0;
    k = 0;
    while (s_busy && k < 500) begin
      @(negedge clk); k++;
    end
    chk("clr busy", 128'(s_busy), 128'(0));
    chk("clr cw", 128'(s_cw_seen), 128'(2));
    chk("clr done", 128'(s_done_cnt), 128'(1));
    chk("clr err end", 128'(s_err), 128'(0));
    chk("clr count", 128'(s_count), 128'(2));

    // Reset while a codeword is stalled
    delay_cfg = 0; stall_cfg = 10; stall_left = 10; got_n = 0; done_cnt = 0;
    @(negedge clk); start = 1'b1; root = 7'd5;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!cw_valid && k < 200) begin
      @(negedge clk); k++;
    end
    chk("mid cw_valid", 128'(cw_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid rst ctrl", 128'({cw_valid, busy, node_req, done}), 128'(0));
    chk("mid rst count", 128'({cw_count, cw_len}), 128'(0));
    repeat (3) @(negedge clk);
    chk("mid no done", 128'(done_cnt), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid idle", 128'(busy), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
